// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Byte-wide memory bus between the CPU (initiator) and the memory
//   responder.
//   addr             byte address              (master -> slave)
//   data_in          write data                (master -> slave)
//   memory_read_en   read request, level       (master -> slave)
//   memory_write_en  write strobe, level       (master -> slave)
//   data_out         read data                 (slave -> master)
//   memory_ready     read data valid for addr  (slave -> master)
interface mem_responder_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              memory_read_en;
  logic              memory_write_en;
  logic              memory_ready;

  modport master (
    output addr, data_in, memory_read_en, memory_write_en,
    input  data_out, memory_ready
  );

  modport slave (
    input  addr, data_in, memory_read_en, memory_write_en,
    output data_out, memory_ready
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Byte-wide memory slave holding the unified array (program bytes,
//   function table, operand stack, call stack). Reads use a level
//   handshake with READ_LATENCY edges of latency. Writes are posted and
//   are committed on every edge that samples write_en.
//
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous reset, active-high
//     bus           mem_responder_if.slave (addr, data_in, data_out,
//                   memory_read_en, memory_write_en, memory_ready)
//     access_error  sticky out-of-range / protected-write flag
//
//   Build option:
//     WRITE_PROTECT_EN  when defined, writes below RO_LIMIT are dropped
//                       and flag access_error.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | no read in flight, waiting for a sampled read request
//   WAIT  | read latched in addr_q, counting down the latency
//   READY | data_out valid for addr_q, ready held while request holds
module mem_responder #(
  parameter int ADDR_W       = 32,
  parameter int MEM_BYTES    = 8192,
  parameter int READ_LATENCY = 1,
  parameter int RO_LIMIT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus,
  output logic                  access_error
);

  localparam int IDX_W = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        cnt;
  logic              ready_q;
  logic [7:0]        data_q;

  logic [7:0] mem [MEM_BYTES];

  // Only a solid 1 counts; a released (X/Z) enable is treated as idle.
  logic rd_act;
  logic wr_act;
  assign rd_act = (bus.memory_read_en  === 1'b1);
  assign wr_act = (bus.memory_write_en === 1'b1);

  logic in_range;
  logic same_addr;
  logic ro_hit;
  logic wr_blocked;
  logic [7:0] rd_data;

  assign in_range  = (bus.addr < ADDR_W'(MEM_BYTES));
  assign same_addr = (bus.addr == addr_q);
  assign ro_hit    = (bus.addr < ADDR_W'(RO_LIMIT));

`ifdef WRITE_PROTECT_EN
  assign wr_blocked = ro_hit;
`else
  // Protection disabled: RO_LIMIT stays referenced but has no effect.
  assign wr_blocked = ro_hit & 1'b0;
`endif

  // In WAIT and READY addr equals addr_q whenever data is captured, so the
  // live address serves as rd(addr_q) as well.
  assign rd_data = in_range ? mem[bus.addr[IDX_W-1:0]] : 8'h00;

  assign bus.memory_ready = ready_q & rd_act & same_addr;
  assign bus.data_out     = data_q;

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_act && in_range && !wr_blocked) begin
      mem[bus.addr[IDX_W-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      cnt          <= '0;
      ready_q      <= 1'b0;
      data_q       <= 8'h00;
      access_error <= 1'b0;
    end else if (wr_act) begin
      // Write wins over any read; the read restarts from IDLE afterwards.
      state   <= IDLE;
      ready_q <= 1'b0;
      if (!in_range || wr_blocked) begin
        access_error <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (rd_act) begin
            addr_q <= bus.addr;
            cnt    <= 4'(READ_LATENCY - 1);
            if (READ_LATENCY == 1) begin
              data_q  <= rd_data;
              ready_q <= 1'b1;
              state   <= READY;
              if (!in_range) begin
                access_error <= 1'b1;
              end
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!rd_act || !same_addr) begin
            ready_q <= 1'b0;
            state   <= IDLE;
          end else if (cnt == 4'd1) begin
            data_q  <= rd_data;
            ready_q <= 1'b1;
            state   <= READY;
            if (!in_range) begin
              access_error <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        READY: begin
          // data_q keeps its last value after the request ends.
          if (!rd_act || !same_addr) begin
            ready_q <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
